// File: rtl/joypad_ports.sv
// NES controller ports at $4016/$4017: strobe decode plus two 8-bit serial shift registers.
// Optional JOYPAD_OPPOSING_DIR_MASK_EN clears impossible UP+DOWN / LEFT+RIGHT combinations at load.
module joypad_ports #(
    parameter logic [15:0] PORT_1_ADDR   = 16'h4016,
    parameter logic [15:0] PORT_2_ADDR   = 16'h4017,
    parameter logic [2:0]  OPEN_BUS_BITS = 3'b010
) (
    input  logic        cpu_clk_i,
    input  logic        cpu_rst_i,
    input  logic        cpu_en_i,
    input  logic        cpu_rw_i,
    input  logic [15:0] cpu_addr_i,
    input  logic [7:0]  cpu_data_i,
    output logic [7:0]  cpu_data_o,
    output logic        cpu_data_valid_o,
    input  logic [7:0]  device_1_input_i,
    input  logic [7:0]  device_2_input_i
);

    function automatic logic [7:0] mask_dirs(input logic [7:0] raw);
        logic [7:0] masked;
        masked = raw;
`ifdef JOYPAD_OPPOSING_DIR_MASK_EN
        if (raw[4] && raw[5]) masked[5:4] = 2'b00;
        if (raw[6] && raw[7]) masked[7:6] = 2'b00;
`endif
        return masked;
    endfunction

    logic       strobe_r;
    logic [7:0] shift_1_r, shift_2_r;
    logic [3:0] count_1_r, count_2_r;

    logic       wr_hit, rd_hit_1, rd_hit_2, load;
    logic [7:0] dev_1_m, dev_2_m;
    logic       rd_bit;
    logic       unused_data;

    assign wr_hit   = cpu_en_i && !cpu_rw_i && (cpu_addr_i == PORT_1_ADDR);
    assign rd_hit_1 = cpu_en_i &&  cpu_rw_i && (cpu_addr_i == PORT_1_ADDR);
    assign rd_hit_2 = cpu_en_i &&  cpu_rw_i && (cpu_addr_i == PORT_2_ADDR);
    // A write of 1 loads on the same edge that raises the strobe.
    assign load     = strobe_r || (wr_hit && cpu_data_i[0]);
    assign dev_1_m  = mask_dirs(device_1_input_i);
    assign dev_2_m  = mask_dirs(device_2_input_i);
    assign unused_data = ^cpu_data_i[7:1];

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        rd_bit = 1'b0;
        if (rd_hit_1)      rd_bit = load ? dev_1_m[0] : shift_1_r[0];
        else if (rd_hit_2) rd_bit = load ? dev_2_m[0] : shift_2_r[0];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
        if (cpu_rst_i) begin
            strobe_r         <= 1'b0;
            shift_1_r        <= 8'hFF;
            shift_2_r        <= 8'hFF;
            count_1_r        <= 4'd8;
            count_2_r        <= 4'd8;
            cpu_data_o       <= 8'h00;
            cpu_data_valid_o <= 1'b0;
        end else begin
            if (wr_hit) strobe_r <= cpu_data_i[0];

            if (load) begin
                shift_1_r <= dev_1_m;
                shift_2_r <= dev_2_m;
                count_1_r <= 4'd0;
                count_2_r <= 4'd0;
            end else begin
                // Shift in 1s so an exhausted register reads 1, like the official pad.
                if (rd_hit_1) begin
                    shift_1_r <= {1'b1, shift_1_r[7:1]};
                    count_1_r <= (count_1_r == 4'd8) ? 4'd8 : count_1_r + 4'd1;
                end
                if (rd_hit_2) begin
                    shift_2_r <= {1'b1, shift_2_r[7:1]};
                    count_2_r <= (count_2_r == 4'd8) ? 4'd8 : count_2_r + 4'd1;
                end
            end

            cpu_data_valid_o <= rd_hit_1 || rd_hit_2;
            if (rd_hit_1 || rd_hit_2) cpu_data_o <= {OPEN_BUS_BITS, 4'b0000, rd_bit};
        end
    end

endmodule

// File: tb/tb_joypad_ports.sv
// Directed self-checking bench for joypad_ports: serial reads, port independence,
// live strobe reads, reset abort, direction masking and non-decoded accesses.
module tb_joypad_ports;

    logic        cpu_clk_i = 1'b0;
    logic        cpu_rst_i = 1'b0;
    logic        cpu_en_i = 1'b0;
    logic        cpu_rw_i = 1'b1;
    logic [15:0] cpu_addr_i = 16'h0000;
    logic [7:0]  cpu_data_i = 8'h00;
    logic [7:0]  cpu_data_o;
    logic        cpu_data_valid_o;
    logic [7:0]  device_1_input_i = 8'h00;
    logic [7:0]  device_2_input_i = 8'h00;

    int vectors = 0;
    int miscompares = 0;

    joypad_ports dut (
        .cpu_clk_i        (cpu_clk_i),
        .cpu_rst_i        (cpu_rst_i),
        .cpu_en_i         (cpu_en_i),
        .cpu_rw_i         (cpu_rw_i),
        .cpu_addr_i       (cpu_addr_i),
        .cpu_data_i       (cpu_data_i),
        .cpu_data_o       (cpu_data_o),
        .cpu_data_valid_o (cpu_data_valid_o),
        .device_1_input_i (device_1_input_i),
        .device_2_input_i (device_2_input_i)
    );

    always #5 cpu_clk_i = ~cpu_clk_i;

    // One bus access, driven at the falling edge and sampled 1 time unit after the rising edge.
    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
        @(negedge cpu_clk_i);
        cpu_en_i = 1'b1; cpu_rw_i = 1'b0; cpu_addr_i = addr; cpu_data_i = data;
        @(posedge cpu_clk_i); #1;
        cpu_en_i = 1'b0; cpu_rw_i = 1'b1;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [7:0] data, output logic valid);
        @(negedge cpu_clk_i);
        cpu_en_i = 1'b1; cpu_rw_i = 1'b1; cpu_addr_i = addr;
        @(posedge cpu_clk_i); #1;
        data = cpu_data_o; valid = cpu_data_valid_o;
        cpu_en_i = 1'b0;
    endtask

    task automatic strobe();
        bus_write(16'h4016, 8'h01);
        bus_write(16'h4016, 8'h00);
    endtask

    task automatic test_reset();
        logic [7:0] d; logic v;
        cpu_rst_i = 1'b1; #12;
        vectors++;
        if (cpu_data_o !== 8'h00 || cpu_data_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: data=%h valid=%b, want data=00 valid=0", cpu_data_o, cpu_data_valid_o);
        end
        @(negedge cpu_clk_i); cpu_rst_i = 1'b0;
        bus_read(16'h4016, d, v);
        vectors++;
        if (d !== 8'h41 || v !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_first_read: data=%h valid=%b, want 41/1", d, v);
        end
    endtask

    task automatic test_basic_serial();
        logic [9:0] bits; logic [7:0] d; logic v;
        bits = 10'b11_1010_0101; // A5 LSB first, then two 1s after exhaustion
        device_1_input_i = 8'hA5;
        strobe();
        device_1_input_i = 8'h00; // must be invisible with the strobe low
        for (int i = 0; i < 10; i++) begin
            bus_read(16'h4016, d, v);
            vectors++;
            if (d !== {7'b0100000, bits[i]} || v !== 1'b1) begin
                miscompares++;
                $display("FAIL basic_read_%0d: data=%h valid=%b, want %h/1", i, d, v, {7'b0100000, bits[i]});
            end
        end
        @(posedge cpu_clk_i); #1;
        vectors++;
        if (cpu_data_valid_o !== 1'b0 || cpu_data_o !== 8'h41) begin
            miscompares++;
            $display("FAIL valid_pulse_width: data=%h valid=%b, want 41/0", cpu_data_o, cpu_data_valid_o);
        end
    endtask

    task automatic test_port_independence();
        logic [7:0] p1, p2, d; logic v;
        p1 = 8'hA5; p2 = 8'h0F;
        device_1_input_i = p1; device_2_input_i = p2;
        strobe();
        for (int i = 0; i < 8; i++) begin
            bus_read(16'h4017, d, v);
            vectors++;
            if (d !== {7'b0100000, p2[i]} || v !== 1'b1) begin
                miscompares++;
                $display("FAIL port2_read_%0d: data=%h valid=%b, want %h/1", i, d, v, {7'b0100000, p2[i]});
            end
            bus_read(16'h4016, d, v);
            vectors++;
            if (d !== {7'b0100000, p1[i]}) begin
                miscompares++;
                $display("FAIL port1_interleave_%0d: data=%h, want %h", i, d, {7'b0100000, p1[i]});
            end
        end
    endtask

    task automatic test_strobe_held();
        logic [2:0] a_seq; logic [2:0] after; logic [7:0] d; logic v;
        a_seq = 3'b010; after = 3'b100; // A4 frozen: bits 0,1,2 = 0,0,1
        bus_write(16'h4016, 8'h01);
        for (int i = 0; i < 3; i++) begin
            device_1_input_i = {7'b1010010, a_seq[i]};
            bus_read(16'h4016, d, v);
            vectors++;
            if (d !== {7'b0100000, a_seq[i]}) begin
                miscompares++;
                $display("FAIL live_a_%0d: data=%h, want %h", i, d, {7'b0100000, a_seq[i]});
            end
        end
        bus_write(16'h4016, 8'h00);
        device_1_input_i = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            bus_read(16'h4016, d, v);
            vectors++;
            if (d !== {7'b0100000, after[i]}) begin
                miscompares++;
                $display("FAIL frozen_after_strobe_%0d: data=%h, want %h", i, d, {7'b0100000, after[i]});
            end
        end
    endtask

    task automatic test_reset_mid_sequence();
        logic [7:0] d; logic v;
        device_1_input_i = 8'h00;
        strobe();
        for (int i = 0; i < 3; i++) bus_read(16'h4016, d, v);
        vectors++;
        if (d !== 8'h40 || v !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_read: data=%h valid=%b, want 40/1", d, v);
        end
        #1 cpu_rst_i = 1'b1; #1;
        vectors++;
        if (cpu_data_o !== 8'h00 || cpu_data_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: data=%h valid=%b, want 00/0", cpu_data_o, cpu_data_valid_o);
        end
        @(negedge cpu_clk_i); cpu_rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_read(16'h4016, d, v);
            vectors++;
            if (d !== 8'h41 || v !== 1'b1) begin
                miscompares++;
                $display("FAIL post_reset_read_%0d: data=%h valid=%b, want 41/1", i, d, v);
            end
        end
    endtask

    task automatic test_direction_mask();
        logic [7:0] exp_bits; logic [7:0] d; logic v;
`ifdef JOYPAD_OPPOSING_DIR_MASK_EN
        exp_bits = 8'h00;
`else
        exp_bits = 8'hF0;
`endif
        device_1_input_i = 8'hF0;
        strobe();
        for (int i = 0; i < 8; i++) begin
            bus_read(16'h4016, d, v);
            vectors++;
            if (d !== {7'b0100000, exp_bits[i]}) begin
                miscompares++;
                $display("FAIL dir_mask_bit_%0d: data=%h, want %h", i, d, {7'b0100000, exp_bits[i]});
            end
        end
    endtask

    task automatic test_non_decoded();
        logic [7:0] d; logic v;
        device_1_input_i = 8'h00;
        strobe();
        bus_write(16'h4017, 8'h01);
        vectors++;
        if (cpu_data_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL write_4017_valid: valid=%b, want 0", cpu_data_valid_o);
        end
        device_1_input_i = 8'h01; // would be seen if the 4017 write had raised the strobe
        bus_read(16'h4015, d, v);
        vectors++;
        if (v !== 1'b0 || d !== 8'h41) begin
            miscompares++;
            $display("FAIL read_4015: data=%h valid=%b, want held 41/0", d, v);
        end
        bus_read(16'h4016, d, v);
        vectors++;
        if (d !== 8'h40 || v !== 1'b1) begin
            miscompares++;
            $display("FAIL strobe_unchanged: data=%h valid=%b, want 40/1", d, v);
        end
    endtask

    initial begin
        test_reset();
        test_basic_serial();
        test_port_independence();
        test_strobe_held();
        test_reset_mid_sequence();
        test_direction_mask();
        test_non_decoded();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
